// File: rtl/lc3_control_fsm.sv
// LC-3 control state machine.
//
// Sequences instruction fetch (F1..F3), decode (DEC) and execute for ADD,
// AND, NOT, BR, JMP, JSR/JSRR, LDR, STR and PAUSE. Unsupported opcodes
// fall back to a new fetch. SRAM read and write strobes are held low for
// MEM_WAIT cycles, timed by a 3-bit wait counter.
//
// Ports
//   Clk, Reset          clock, asynchronous active-low reset
//   Run                 leaves HALTED when high
//   Continue            releases a PAUSE (high then low)
//   IR[15:0], BEN       instruction register and branch-enable flag
//   LD_*                register load enables
//   Gate*               bus drivers (at most one high per cycle)
//   PCMUX, DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK  datapath selects
//   Mem_OE, Mem_WE      active-low SRAM strobes
module lc3_control_fsm #(
  parameter int MEM_WAIT = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Run,
  input  logic        Continue,
  input  logic [15:0] IR,
  input  logic        BEN,
  output logic        LD_MAR,
  output logic        LD_MDR,
  output logic        LD_IR,
  output logic        LD_BEN,
  output logic        LD_CC,
  output logic        LD_REG,
  output logic        LD_PC,
  output logic        LD_LED,
  output logic        GatePC,
  output logic        GateMDR,
  output logic        GateALU,
  output logic        GateMARMUX,
  output logic [1:0]  PCMUX,
  output logic        DRMUX,
  output logic        SR1MUX,
  output logic        SR2MUX,
  output logic        ADDR1MUX,
  output logic [1:0]  ADDR2MUX,
  output logic [1:0]  ALUK,
  output logic        Mem_OE,
  output logic        Mem_WE
);

  typedef enum logic [4:0] {
    HALTED, F1, F2, F3, DEC,
    S_ADD, S_AND, S_NOT, S_BR, S_JMP,
    JSR1, JSR2, LDR1, LDR2, LDR3,
    STR1, STR2, STR3,
    PAUSE1, PAUSE2, PAUSE3
  } state_t;

  // Counter value on the final cycle of a memory strobe.
  localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT - 1);

  state_t     state;
  state_t     state_next;
  logic [2:0] wait_cnt;
  logic [2:0] wait_cnt_next;
  logic       wait_done;

  // IR bits that no state decodes.
  logic unused_ir;
  assign unused_ir = ^{IR[10:6], IR[4:0]};

  assign wait_done = (wait_cnt == WAIT_LAST);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= HALTED;
      wait_cnt <= 3'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    LD_BEN     = 1'b0;
    LD_CC      = 1'b0;
    LD_REG     = 1'b0;
    LD_PC      = 1'b0;
    LD_LED     = 1'b0;
    GatePC     = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    GateMARMUX = 1'b0;
    PCMUX      = 2'b00;
    DRMUX      = 1'b0;
    SR1MUX     = 1'b0;
    SR2MUX     = 1'b0;
    ADDR1MUX   = 1'b0;
    ADDR2MUX   = 2'b00;
    ALUK       = 2'b00;
    Mem_OE     = 1'b1;
    Mem_WE     = 1'b1;

    unique case (state)
      HALTED: begin
        if (Run) state_next = F1;
      end
      F1: begin
        GatePC     = 1'b1;
        LD_MAR     = 1'b1;
        LD_PC      = 1'b1;
        PCMUX      = 2'b00;
        state_next = F2;
      end
      F2, LDR2: begin
        // MDR captures the read data on the last strobe cycle only.
        Mem_OE = 1'b0;
        if (wait_done) begin
          LD_MDR        = 1'b1;
          wait_cnt_next = 3'd0;
          state_next    = (state == F2) ? F3 : LDR3;
        end else begin
          wait_cnt_next = wait_cnt + 3'd1;
        end
      end
      F3: begin
        GateMDR    = 1'b1;
        LD_IR      = 1'b1;
        state_next = DEC;
      end
      DEC: begin
        LD_BEN = 1'b1;
        case (IR[15:12])
          4'b0001: state_next = S_ADD;
          4'b0101: state_next = S_AND;
          4'b1001: state_next = S_NOT;
          4'b0000: state_next = S_BR;
          4'b1100: state_next = S_JMP;
          4'b0100: state_next = JSR1;
          4'b0110: state_next = LDR1;
          4'b0111: state_next = STR1;
          4'b1101: state_next = PAUSE1;
          default: state_next = F1;
        endcase
      end
      S_ADD, S_AND, S_NOT: begin
        GateALU    = 1'b1;
        LD_REG     = 1'b1;
        LD_CC      = 1'b1;
        SR1MUX     = 1'b1;
        SR2MUX     = (state == S_NOT) ? 1'b0 : IR[5];
        ALUK       = (state == S_ADD) ? 2'b00 :
                     (state == S_AND) ? 2'b01 : 2'b10;
        state_next = F1;
      end
      S_BR: begin
        // BEN was latched in DEC, so it is stable for this cycle.
        if (BEN) begin
          LD_PC    = 1'b1;
          PCMUX    = 2'b10;
          ADDR1MUX = 1'b0;
          ADDR2MUX = 2'b10;
        end
        state_next = F1;
      end
      S_JMP: begin
        LD_PC      = 1'b1;
        PCMUX      = 2'b10;
        ADDR1MUX   = 1'b1;
        SR1MUX     = 1'b1;
        ADDR2MUX   = 2'b00;
        state_next = F1;
      end
      JSR1: begin
        GatePC     = 1'b1;
        LD_REG     = 1'b1;
        DRMUX      = 1'b1;
        state_next = JSR2;
      end
      JSR2: begin
        LD_PC = 1'b1;
        PCMUX = 2'b10;
        // IR[11] selects PC-relative JSR versus register-based JSRR.
        if (IR[11]) begin
          ADDR1MUX = 1'b0;
          ADDR2MUX = 2'b11;
        end else begin
          ADDR1MUX = 1'b1;
          SR1MUX   = 1'b1;
          ADDR2MUX = 2'b00;
        end
        state_next = F1;
      end
      LDR1, STR1: begin
        GateMARMUX = 1'b1;
        LD_MAR     = 1'b1;
        ADDR1MUX   = 1'b1;
        SR1MUX     = 1'b1;
        ADDR2MUX   = 2'b01;
        state_next = (state == LDR1) ? LDR2 : STR2;
      end
      LDR3: begin
        GateMDR    = 1'b1;
        LD_REG     = 1'b1;
        LD_CC      = 1'b1;
        state_next = F1;
      end
      STR2: begin
        // Source register (IR[11:9]) passes through the ALU into MDR.
        GateALU    = 1'b1;
        ALUK       = 2'b11;
        SR1MUX     = 1'b0;
        LD_MDR     = 1'b1;
        state_next = STR3;
      end
      STR3: begin
        Mem_WE = 1'b0;
        if (wait_done) begin
          wait_cnt_next = 3'd0;
          state_next    = F1;
        end else begin
          wait_cnt_next = wait_cnt + 3'd1;
        end
      end
      PAUSE1: begin
        LD_LED     = 1'b1;
        state_next = PAUSE2;
      end
      PAUSE2: begin
        if (Continue) state_next = PAUSE3;
      end
      PAUSE3: begin
        if (!Continue) state_next = F1;
      end
      default: begin
        state_next    = HALTED;
        wait_cnt_next = 3'd0;
      end
    endcase
  end

endmodule
